// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - pipeline register stage with optional skid entry and flush
module pipe_skid_stage #(
  parameter int WIDTH          = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_next = BUSY;
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_next = (SKID != 0) ? FULL : BUSY;
          end else if (out_fire && !in_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) state_next = BUSY;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // With SKID=1 in_ready depends only on state and flush, keeping out_ready off the upstream path.
  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = main_q;
    if (SKID != 0) begin
      in_ready = (state != FULL) && !flush;
    end else begin
      in_ready = (!out_valid || out_ready) && !flush;
    end
    case (state)
      BUSY:    count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) main_q <= in_data;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire && (SKID != 0)) begin
            skid_q <= in_data;
          end
        end
        FULL: begin
          if (out_fire) main_q <= skid_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (legal range 1..256).
REQ-002 The block SHALL have parameter SKID, default 1: 1 selects a two-entry skid stage with registered in_ready; 0 selects a single-entry stage with combinational in_ready.
REQ-003 The block SHALL have parameter CLEAR_ON_FLUSH, default 1: 1 zeroes the data registers on flush; 0 leaves them holding their values.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept the payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 flush  input  1  discard all held entries (branch/jump squash).
REQ-011 out_valid  output  1  stage holds a valid payload.
REQ-012 out_ready  input  1  downstream accepts the payload this cycle.
REQ-013 out_data  output  WIDTH  payload at the head of the stage.
REQ-014 count  output  2  number of held entries, 0..2.

Function
REQ-015 Handshakes SHALL be defined as: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready.
REQ-016 The block SHALL use states EMPTY (count 0), BUSY (count 1, entry in main), and FULL (count 2, main plus skid); FULL SHALL be reachable only when SKID=1.
REQ-017 out_valid SHALL be (state != EMPTY) and out_data SHALL equal main, driven directly from registers.
REQ-018 When SKID=1, in_ready SHALL be (state != FULL) & !flush, with no combinational path from out_ready.
REQ-019 When SKID=0, in_ready SHALL be (!out_valid | out_ready) & !flush.
REQ-020 From EMPTY, an in-fire SHALL load main with in_data and go to BUSY; otherwise the state SHALL hold.
REQ-021 From BUSY, the following transitions SHALL apply:
- in-fire and out-fire: load main with in_data, stay BUSY.
- in-fire without out-fire (SKID=1 only): load skid with in_data, go to FULL.
- out-fire without in-fire: go to EMPTY.
- otherwise: hold.
REQ-022 From FULL, an out-fire SHALL move skid to main and go to BUSY; otherwise the state SHALL hold (in_ready is 0, so no input is accepted).
REQ-023 Latency from in-fire to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 transfer per cycle when out_ready is held high.
REQ-024 Ordering SHALL be strict FIFO; no payload is dropped or duplicated except by flush or reset.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL stay unchanged cycle to cycle.
REQ-026 flush SHALL override all handshakes:
- the next state is EMPTY and count becomes 0.
- any in_valid in the flush cycle is not accepted.
- out-fire in the flush cycle is still reported to downstream, but the stage discards the entry.
REQ-027 With CLEAR_ON_FLUSH=1, flush SHALL zero main and skid; with CLEAR_ON_FLUSH=0 they SHALL hold their values.
REQ-028 count SHALL equal 0, 1 or 2 for EMPTY, BUSY or FULL respectively, and SHALL never take the value 3.

Reset
REQ-029 reset SHALL take priority over flush and handshakes.
REQ-030 On reset, the stage SHALL go to EMPTY and zero main and skid, giving out_valid=0, out_data=0 and count=0.
REQ-031 On reset, in_ready SHALL be 1 from the first cycle after reset when flush=0.
REQ-032 A reset asserted mid-transfer SHALL discard both entries, and no payload accepted before reset SHALL appear at the output afterwards.

Verification
REQ-033 Streaming: SKID=1, out_ready=1, in_valid=1 with in_data 0x10,0x11,0x12 on consecutive cycles -> out_data 0x10,0x11,0x12 on the next three cycles, out_valid=1 throughout, count=1.
REQ-034 Backpressure: BUSY holding 0xA0, out_ready=0, in 0xA1 -> FULL, in_ready=0, out_data stays 0xA0; then out_ready=1 for 2 cycles -> outputs 0xA0 then 0xA1, final state EMPTY.
REQ-035 Flush: FULL holding 0xB0/0xB1, flush=1 with in_valid=1, in_data=0xB2 -> next cycle out_valid=0, count=0, main=skid=0; 0xB2 never appears at the output.
REQ-036 SKID=0: BUSY, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle, with back-to-back transfer.
REQ-037 Reset mid-operation: FULL, reset=1 for 1 cycle -> out_valid=0, out_data=0, count=0, in_ready=1 the following cycle.
REQ-038 Random: 10k cycles of random in_valid/out_ready/flush with a scoreboard -> no ordering error, no loss outside flush, count never 3, out_data stable under stall.
